// File: rtl/fifo_wr_ctrl.sv
// Purpose: write-side pointer controller for a dual-clock FIFO (clk1 domain), with full/almost-full/level/overflow.
// Latency: mem_we/waddr combinational; pointer and flags update 1 edge after accept, read-pointer moves seen SYNC_STAGES edges later.
// Backpressure: wr_req is refused while full (no pointer move, no mem_we); a refused request sets the sticky overflow flag.
module fifo_wr_ctrl #(
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = 6
) (
    input  logic              clk1,
    input  logic              rst1,
    input  logic              wr_req,
    input  logic              clr_ovf,
    input  logic [ADDR_W:0]   rptr_gray,
    output logic [ADDR_W:0]   wptr_gray,
    output logic [ADDR_W-1:0] waddr,
    output logic              mem_we,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wr_level,
    output logic              overflow
);

    // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
    localparam logic [ADDR_W:0] FULL_MASK = {2'b11, {(ADDR_W-1){1'b0}}};
    localparam logic [ADDR_W:0] AF_LVL    = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W+1)'(1);

    logic [ADDR_W:0] wbin;
    logic [ADDR_W:0] wgray;
    logic [ADDR_W:0] wbin_nxt;
    logic [ADDR_W:0] sync_q [SYNC_STAGES];
    logic [ADDR_W:0] rsync;
    logic [ADDR_W:0] rbin;
    logic            ovf;
    logic            accept;

    assign rsync    = sync_q[SYNC_STAGES-1];
    assign wbin_nxt = wbin + PTR_ONE;

    // Gray-to-binary of the synchronised read pointer: bit i is the XOR of all Gray bits at and above i.
    always_comb begin
        rbin = '0;
        for (int i = 0; i <= ADDR_W; i++) begin
            rbin[i] = ^(rsync >> i);
        end
    end

    // Status flags derive only from registers, so they never glitch on wr_req.
    always_comb begin
        wr_level    = wbin - rbin;
        full        = (wgray == (rsync ^ FULL_MASK));
        almost_full = (wr_level >= AF_LVL);
    end

    // Accept gating includes rst1 so no write strobe leaks out while reset is held.
    always_comb begin
        accept = wr_req & ~full & ~rst1;
        mem_we = accept;
        waddr  = wbin[ADDR_W-1:0];
    end

    assign wptr_gray = wgray;
    assign overflow  = ovf;

    // Write pointer: binary and registered Gray copies advance together on an accepted write.
    always_ff @(posedge clk1 or posedge rst1) begin
        if (rst1) begin
            wbin  <= '0;
            wgray <= '0;
        end else if (accept) begin
            wbin  <= wbin_nxt;
            wgray <= wbin_nxt ^ (wbin_nxt >> 1);
        end
    end

    // Read-pointer synchroniser chain; Gray coding keeps each sampled value within one step of the truth.
    always_ff @(posedge clk1 or posedge rst1) begin
        if (rst1) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= rptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Sticky overflow: a new refused write outranks a simultaneous clear.
    always_ff @(posedge clk1 or posedge rst1) begin
        if (rst1) begin
            ovf <= 1'b0;
        end else begin
            ovf <= (wr_req & full) | (ovf & ~clr_ovf);
        end
    end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Purpose: directed self-checking bench for fifo_wr_ctrl (ADDR_W=3, SYNC_STAGES=2, AF_THRESH=6).
// Latency: inputs driven 1 time unit after posedge; combinational outputs checked 1 unit later, registered ones after each edge.
// Backpressure: exercises refused writes when full, overflow set/clear, and synchroniser delay on read-pointer moves.
module tb_fifo_wr_ctrl;

    logic       clk1 = 1'b0;
    logic       rst1;
    logic       wr_req;
    logic       clr_ovf;
    logic [3:0] rptr_gray;
    logic [3:0] wptr_gray;
    logic [2:0] waddr;
    logic       mem_we;
    logic       full;
    logic       almost_full;
    logic [3:0] wr_level;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    fifo_wr_ctrl #(.ADDR_W(3), .SYNC_STAGES(2), .AF_THRESH(6)) dut (
        .clk1        (clk1),
        .rst1        (rst1),
        .wr_req      (wr_req),
        .clr_ovf     (clr_ovf),
        .rptr_gray   (rptr_gray),
        .wptr_gray   (wptr_gray),
        .waddr       (waddr),
        .mem_we      (mem_we),
        .full        (full),
        .almost_full (almost_full),
        .wr_level    (wr_level),
        .overflow    (overflow)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wptr"},  32'(wptr_gray),   0);
        check({tag, "_waddr"}, 32'(waddr),       0);
        check({tag, "_lvl"},   32'(wr_level),    0);
        check({tag, "_full"},  32'(full),        0);
        check({tag, "_af"},    32'(almost_full), 0);
        check({tag, "_ovf"},   32'(overflow),    0);
        check({tag, "_we"},    32'(mem_we),      0);
    endtask

    // Gray code of a 4-bit binary pointer value.
    function automatic logic [3:0] g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    initial begin
        logic [3:0] exp_gray [8] = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};
        logic [3:0] rp;
        int n;

        rst1 = 1'b1; wr_req = 1'b0; clr_ovf = 1'b0; rptr_gray = '0;
        tick(); tick();
        check_all_zero("rst");
        rst1 = 1'b0;

        // Fill from empty with rptr held at 0, then two refused writes.
        for (int k = 0; k < 10; k++) begin
            wr_req = 1'b1;
            #1;
            check("fill_we", 32'(mem_we), (k < 8) ? 1 : 0);
            if (k < 8) check("fill_waddr", 32'(waddr), 32'(k));
            tick();
            n = (k < 8) ? k + 1 : 8;
            check("fill_wptr", 32'(wptr_gray), 32'(exp_gray[n-1]));
            check("fill_lvl",  32'(wr_level), 32'(n));
            check("fill_af",   32'(almost_full), (n >= 6) ? 1 : 0);
            check("fill_full", 32'(full), (n == 8) ? 1 : 0);
            check("fill_ovf",  32'(overflow), (k >= 8) ? 1 : 0);
        end

        // Overflow clear with no write, re-set, then set beats clear.
        wr_req = 1'b0; clr_ovf = 1'b1;
        tick();
        check("clr_ovf", 32'(overflow), 0);
        clr_ovf = 1'b0; wr_req = 1'b1;
        #1;
        check("rej_we", 32'(mem_we), 0);
        tick();
        check("reset_ovf", 32'(overflow), 1);
        clr_ovf = 1'b1;
        tick();
        check("set_wins_ovf", 32'(overflow), 1);
        check("set_wins_lvl", 32'(wr_level), 8);
        wr_req = 1'b0;
        tick();
        check("clr2_ovf", 32'(overflow), 0);
        clr_ovf = 1'b0;

        // Read pointer jumps to binary 3; visible after exactly two edges.
        rptr_gray = 4'd2;
        tick();
        check("rd1_full", 32'(full), 1);
        check("rd1_lvl",  32'(wr_level), 8);
        tick();
        check("rd2_full", 32'(full), 0);
        check("rd2_lvl",  32'(wr_level), 5);
        check("rd2_af",   32'(almost_full), 0);

        // Reader catches up, then tracks the writer for 20 writes across two waddr wraps.
        rptr_gray = g(4'd8);
        tick(); tick();
        check("trk0_lvl", 32'(wr_level), 0);
        for (int i = 0; i < 20; i++) begin
            wr_req = 1'b1;
            rp = 4'(8 + i);
            rptr_gray = g(rp);
            #1;
            check("trk_waddr", 32'(waddr), 32'(i % 8));
            check("trk_we",    32'(mem_we), 1);
            tick();
            rp = 4'(9 + i);
            check("trk_wptr", 32'(wptr_gray), 32'(g(rp)));
            check("trk_lvl",  32'(wr_level), (i == 0) ? 1 : 2);
            check("trk_full", 32'(full), 0);
        end
        wr_req = 1'b0;
        tick(); tick();
        check("trk_end_lvl", 32'(wr_level), 1);

        // Build level 4, then reset asynchronously in the middle of a write cycle.
        wr_req = 1'b1;
        tick(); tick(); tick();
        check("pre_rst_lvl", 32'(wr_level), 4);
        #1;
        check("pre_rst_waddr", 32'(waddr), 7);
        check("pre_rst_we",    32'(mem_we), 1);
        rst1 = 1'b1; rptr_gray = '0;
        #1;
        check_all_zero("arst");
        tick();
        check("arst_hold_we",   32'(mem_we), 0);
        check("arst_hold_wptr", 32'(wptr_gray), 0);
        rst1 = 1'b0;
        #1;
        check("post_rst_waddr", 32'(waddr), 0);
        check("post_rst_we",    32'(mem_we), 1);
        tick();
        check("post_rst_wptr", 32'(wptr_gray), 1);
        check("post_rst_lvl",  32'(wr_level), 1);

        // Reach level 7, then write and advance the read pointer in the same cycle.
        for (int i = 0; i < 6; i++) tick();
        check("l7_lvl",  32'(wr_level), 7);
        check("l7_af",   32'(almost_full), 1);
        check("l7_full", 32'(full), 0);
        rptr_gray = g(4'd1);
        #1;
        check("sim_we", 32'(mem_we), 1);
        tick();
        check("sim1_full", 32'(full), 1);
        check("sim1_lvl",  32'(wr_level), 8);
        wr_req = 1'b0;
        tick();
        check("sim2_full", 32'(full), 0);
        check("sim2_lvl",  32'(wr_level), 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
